adder_resp_checker: RTL and testbench
=====================================

# adder_resp_checker

Registered response checker for the N-bit Adder: the receiving end of the operand stream a bench or traffic source drives into the Adder. It sees every operand triple issued to the Adder and computes the expected {Cout, Sum}. It delays the expectation to match the Adder's pipeline latency and compares it against the Adder's actual outputs. Results go into saturating pass/fail counters and a sticky first-error capture record, so self-checking benches and on-chip BIST can share one checker.

## Interface
Parameters:
- WIDTH, 32, operand/sum width in bits (1..64)
- LAT, 1, Adder latency in TClk cycles from operand sample to Sum/Cout valid (1..8)

Ports:
- TClk  in  1  clock, rising edge
- TRst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of counters, capture record, state and pipeline
- in_valid  in  1  ra/rb/cin are being issued to the Adder this cycle
- ra  in  WIDTH  operand A as issued
- rb  in  WIDTH  operand B as issued
- cin  in  1  carry-in as issued
- Sum  in  WIDTH  Adder sum output
- Cout  in  1  Adder carry output
- chk_pulse  out  1  one-cycle pulse when a comparison completes
- chk_pass  out  1  result of that comparison; meaningful only while chk_pulse=1
- pass_cnt  out  16  matches, saturating
- fail_cnt  out  16  mismatches, saturating
- state  out  2  00 IDLE, 01 PASSING, 10 FAILED
- err_flag  out  1  sticky: at least one mismatch since reset/clear
- err_ra, err_rb  out  WIDTH  operands of the first mismatch
- err_cin  out  1  carry-in of the first mismatch
- err_exp  out  WIDTH+1  expected {Cout,Sum} of the first mismatch
- err_got  out  WIDTH+1  observed {Cout,Sum} of the first mismatch

## Operation
- Expected value: exp = ra + rb + cin, evaluated in WIDTH+1 bits (zero-extended operands). The MSB is the expected Cout. No truncation.
- Pipeline: LAT-deep shift register of {valid, exp, ra, rb, cin}. Stage 0 loads on every edge with in_valid as its valid bit. Bubbles (in_valid=0) propagate as invalid entries.
- Compare: when the head entry (stage LAT-1) is valid at an edge, the checker samples {Cout,Sum} on that same edge and compares against head exp.
  - Match: pass_cnt increments, saturating at 0xFFFF.
  - Mismatch: fail_cnt increments, saturating at 0xFFFF. If err_flag=0, load err_ra/err_rb/err_cin/err_exp/err_got from the head entry and the observed outputs, then set err_flag.
  - Later mismatches update only fail_cnt; the capture record holds the first mismatch.
- FSM:
  - IDLE -> PASSING on the first match.
  - IDLE -> FAILED on the first mismatch.
  - PASSING -> FAILED on any mismatch.
  - FAILED is absorbing until clear or reset.
  - No check has no state effect.
- clear=1 at an edge:
  - counters, err_* fields, err_flag, chk_pulse -> 0; state -> IDLE.
  - All pipeline valid bits -> 0. in_valid at that edge is dropped, and any comparison due at that edge is discarded without counting.
- Reset (TRst_n=0, asynchronous, any time including mid-stream): every output goes to 0 and state to IDLE, and all pipeline valid bits clear. In-flight operands are discarded, never counted.
- Sum/Cout are ignored on edges where the head entry is invalid; X on them then is legal.

## Timing
- Operand sampled at edge E0 (in_valid=1). It is compared at edge E_LAT, and chk_pulse/chk_pass are high for the cycle following E_LAT.
- pass_cnt, fail_cnt, state, err_flag and err_* are registered and update at E_LAT, visible in the same cycle as chk_pulse.
- Full throughput: one new operand per cycle, back-to-back, no stall or backpressure.
- Simultaneous compare at the head and new in_valid at stage 0 are independent. Both take effect.
- Saturation: a counter at 0xFFFF stays 0xFFFF. The other counter and the FSM still update normally.

## Test plan
- Reset values: hold TRst_n=0 → all outputs 0 and state=00. Assert TRst_n=0 mid-stream with 3 ops in flight (LAT=3), then release → no counts change and chk_pulse never fires for those ops.
- Correct stream, WIDTH=32, LAT=1: 1000 random ops back-to-back fed to a correct Adder → pass_cnt=1000, fail_cnt=0, state=01, err_flag=0.
- Carry boundary, WIDTH=32: ra=0xFFFFFFFF, rb=0x00000000, cin=1 with the Adder correct → match on exp=0x1_00000000. Force Cout=0 instead → mismatch with err_exp=0x1_00000000 and err_got=0x0_00000000.
- First-error capture, LAT=2: inject mismatches on ops #5 (ra=0x10, rb=0x20, cin=0) and #9 → fail_cnt=2, state=10, err_ra=0x10, err_rb=0x20, err_exp=0x30. The capture record is unchanged by op #9.
- Bubbles and clear: ops with in_valid pattern 1,0,1,1 at LAT=3 → chk_pulse pattern 1,0,1,1 starting 3 cycles later. Assert clear while 2 ops are in flight → both are discarded and counters read 0.
- Saturation: preload by running 65540 matching ops → pass_cnt=0xFFFF. Then one mismatch → fail_cnt=1 and state=10.

Source files
------------

// File: rtl/adder_resp_checker.sv
// rtl/adder_resp_checker.sv - pipelined expected-sum checker for the N-bit Adder
module adder_resp_checker #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             TClk,
  input  logic             TRst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic             cin,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Cout,
  output logic             chk_pulse,
  output logic             chk_pass,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      fail_cnt,
  output logic [1:0]       state,
  output logic             err_flag,
  output logic [WIDTH-1:0] err_ra,
  output logic [WIDTH-1:0] err_rb,
  output logic             err_cin,
  output logic [WIDTH:0]   err_exp,
  output logic [WIDTH:0]   err_got
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_PASSING = 2'b01;
  localparam logic [1:0] S_FAILED  = 2'b10;

  logic [LAT-1:0]   pipe_valid;
  logic [WIDTH:0]   pipe_exp [LAT];
  logic [WIDTH-1:0] pipe_ra  [LAT];
  logic [WIDTH-1:0] pipe_rb  [LAT];
  logic [LAT-1:0]   pipe_cin;

  logic [WIDTH:0] exp_in;
  logic [WIDTH:0] got;
  logic           do_chk;
  logic           match;

  assign exp_in = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, cin};
  assign got    = {Cout, Sum};
  assign do_chk = pipe_valid[LAT-1];
  assign match  = (got == pipe_exp[LAT-1]);

  // Only the valid bits need reset/clear; payload is don't-care while invalid.
  always_ff @(posedge TClk or negedge TRst_n) begin
    if (!TRst_n) begin
      pipe_valid <= '0;
    end else if (clear) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= in_valid;
      for (int i = 1; i < LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge TClk) begin
    pipe_exp[0] <= exp_in;
    pipe_ra[0]  <= ra;
    pipe_rb[0]  <= rb;
    pipe_cin[0] <= cin;
    for (int i = 1; i < LAT; i++) begin
      pipe_exp[i] <= pipe_exp[i-1];
      pipe_ra[i]  <= pipe_ra[i-1];
      pipe_rb[i]  <= pipe_rb[i-1];
      pipe_cin[i] <= pipe_cin[i-1];
    end
  end

  always_ff @(posedge TClk or negedge TRst_n) begin
    if (!TRst_n) begin
      chk_pulse <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      state     <= S_IDLE;
      err_flag  <= 1'b0;
      err_ra    <= '0;
      err_rb    <= '0;
      err_cin   <= 1'b0;
      err_exp   <= '0;
      err_got   <= '0;
    end else if (clear) begin
      chk_pulse <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      state     <= S_IDLE;
      err_flag  <= 1'b0;
      err_ra    <= '0;
      err_rb    <= '0;
      err_cin   <= 1'b0;
      err_exp   <= '0;
      err_got   <= '0;
    end else begin
      chk_pulse <= do_chk;
      chk_pass  <= do_chk & match;
      if (do_chk) begin
        if (match) begin
          if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
          if (state == S_IDLE) state <= S_PASSING;
        end else begin
          if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
          state <= S_FAILED;
          // Capture record holds only the first mismatch since reset/clear.
          if (!err_flag) begin
            err_flag <= 1'b1;
            err_ra   <= pipe_ra[LAT-1];
            err_rb   <= pipe_rb[LAT-1];
            err_cin  <= pipe_cin[LAT-1];
            err_exp  <= pipe_exp[LAT-1];
            err_got  <= got;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_resp_checker.sv
// tb/tb_adder_resp_checker.sv - randomized self-checking bench for adder_resp_checker
module tb_adder_resp_checker;

  localparam int LAT = 3;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        bad;
    logic [32:0] got;
  } op_t;

  logic        TClk = 1'b0;
  logic        TRst_n, clear, in_valid, cin, Cout;
  logic [31:0] ra, rb, Sum;
  logic        chk_pulse, chk_pass, err_flag, err_cin;
  logic [15:0] pass_cnt, fail_cnt;
  logic [1:0]  state;
  logic [31:0] err_ra, err_rb;
  logic [32:0] err_exp, err_got;

  adder_resp_checker #(.WIDTH(32), .LAT(LAT)) dut (
    .TClk(TClk), .TRst_n(TRst_n), .clear(clear), .in_valid(in_valid),
    .ra(ra), .rb(rb), .cin(cin), .Sum(Sum), .Cout(Cout),
    .chk_pulse(chk_pulse), .chk_pass(chk_pass), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .state(state), .err_flag(err_flag),
    .err_ra(err_ra), .err_rb(err_rb), .err_cin(err_cin),
    .err_exp(err_exp), .err_got(err_got)
  );

  always #5 TClk = ~TClk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b1;

  // Ops issued to the modelled Adder, oldest first; q[0] is the one due at the next edge.
  op_t q[$];

  bit          m_pulse, m_cp, m_flag, m_cin;
  int          m_pc, m_fc;
  logic [1:0]  m_st;
  logic [31:0] m_ra, m_rb;
  logic [32:0] m_exp, m_got;

  function automatic logic [32:0] ref_sum(op_t o);
    return {1'b0, o.a} + {1'b0, o.b} + 33'(o.c);
  endfunction

  function automatic op_t mk(logic v, logic [31:0] a, logic [31:0] b, logic c);
    op_t o;
    o.v = v; o.a = a; o.b = b; o.c = c; o.bad = 1'b0; o.got = '0;
    return o;
  endfunction

  function automatic op_t mk_bad(logic [31:0] a, logic [31:0] b, logic c, logic [32:0] g);
    op_t o;
    o = mk(1'b1, a, b, c);
    o.bad = 1'b1; o.got = g;
    return o;
  endfunction

  function automatic op_t rnd_op();
    return mk(1'b1, $urandom, $urandom, 1'($urandom));
  endfunction

  function automatic op_t bubble();
    return mk(1'b0, $urandom, $urandom, 1'($urandom));
  endfunction

  task automatic model_reset();
    m_pulse = 0; m_cp = 0; m_flag = 0; m_cin = 0;
    m_pc = 0; m_fc = 0; m_st = 2'b00;
    m_ra = '0; m_rb = '0; m_exp = '0; m_got = '0;
    foreach (q[i]) q[i].v = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("chk_pulse", 65'(chk_pulse), 65'(m_pulse));
    if (m_pulse) chk("chk_pass", 65'(chk_pass), 65'(m_cp));
    chk("pass_cnt", 65'(pass_cnt), 65'(m_pc));
    chk("fail_cnt", 65'(fail_cnt), 65'(m_fc));
    chk("state", 65'(state), 65'(m_st));
    chk("err_flag", 65'(err_flag), 65'(m_flag));
    chk("err_ra", 65'(err_ra), 65'(m_ra));
    chk("err_rb", 65'(err_rb), 65'(m_rb));
    chk("err_cin", 65'(err_cin), 65'(m_cin));
    chk("err_exp", 65'(err_exp), 65'(m_exp));
    chk("err_got", 65'(err_got), 65'(m_got));
  endtask

  task automatic step(input op_t o, input bit clr);
    op_t h;
    logic [32:0] e, g;
    q.push_back(o);
    h = q[0];
    in_valid = o.v; ra = o.a; rb = o.b; cin = o.c; clear = clr;
    if (h.v) {Cout, Sum} = h.bad ? h.got : ref_sum(h);
    else     {Cout, Sum} = 33'({$urandom, $urandom});
    @(posedge TClk);
    #1;
    void'(q.pop_front());
    if (clr) begin
      model_reset();
    end else if (h.v) begin
      e = ref_sum(h);
      g = h.bad ? h.got : e;
      m_pulse = 1;
      m_cp = (g == e);
      if (g == e) begin
        if (m_pc < 65535) m_pc++;
        if (m_st == 2'b00) m_st = 2'b01;
      end else begin
        if (m_fc < 65535) m_fc++;
        m_st = 2'b10;
        if (!m_flag) begin
          m_flag = 1; m_ra = h.a; m_rb = h.b; m_cin = h.c; m_exp = e; m_got = g;
        end
      end
    end else begin
      m_pulse = 0;
    end
    if (chk_en) check_all();
  endtask

  task automatic drain();
    repeat (LAT) step(bubble(), 1'b0);
  endtask

  task automatic async_rst();
    #2 TRst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("rst_chk_pass", 65'(chk_pass), 65'(0));
    #1 TRst_n = 1'b1;
  endtask

  initial begin
    op_t o;
    TRst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    ra = '0; rb = '0; cin = 1'b0; Sum = '0; Cout = 1'b0;
    repeat (LAT) q.push_back(bubble());
    model_reset();
    repeat (3) @(posedge TClk);
    #1 check_all();
    chk("reset_chk_pass", 65'(chk_pass), 65'(0));
    TRst_n = 1'b1;

    // Correct back-to-back random stream.
    repeat (1000) step(rnd_op(), 1'b0);
    drain();
    chk("stream_pass", 65'(pass_cnt), 65'(1000));
    chk("stream_state", 65'(state), 65'(2'b01));

    // Carry boundary: correct, then Cout forced low.
    step(bubble(), 1'b1);
    step(mk(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1), 1'b0);
    drain();
    chk("carry_pass", 65'(pass_cnt), 65'(1));
    step(mk_bad(32'hFFFF_FFFF, 32'h0, 1'b1, 33'h0_0000_0000), 1'b0);
    drain();
    chk("carry_err_exp", 65'(err_exp), 65'(33'h1_0000_0000));
    chk("carry_err_got", 65'(err_got), 65'(33'h0_0000_0000));

    // First-error capture: mismatches on ops #5 and #9.
    step(bubble(), 1'b1);
    for (int i = 1; i <= 12; i++) begin
      if (i == 5) o = mk_bad(32'h10, 32'h20, 1'b0, 33'h31);
      else if (i == 9) begin
        o = rnd_op();
        o.bad = 1'b1;
        o.got = ref_sum(o) + 33'd1;
      end else o = rnd_op();
      step(o, 1'b0);
    end
    drain();
    chk("first_fail_cnt", 65'(fail_cnt), 65'(2));
    chk("first_err_ra", 65'(err_ra), 65'(32'h10));
    chk("first_err_rb", 65'(err_rb), 65'(32'h20));
    chk("first_err_exp", 65'(err_exp), 65'(33'h30));
    chk("first_state", 65'(state), 65'(2'b10));

    // Bubbles 1,0,1,1 then clear with two ops in flight.
    step(bubble(), 1'b1);
    step(rnd_op(), 1'b0);
    step(bubble(), 1'b0);
    step(rnd_op(), 1'b0);
    step(rnd_op(), 1'b0);
    drain();
    chk("bubble_pass", 65'(pass_cnt), 65'(3));
    step(rnd_op(), 1'b0);
    step(rnd_op(), 1'b0);
    step(bubble(), 1'b1);
    drain();
    chk("clear_pass", 65'(pass_cnt), 65'(0));

    // Asynchronous reset with three ops in flight.
    repeat (5) step(rnd_op(), 1'b0);
    async_rst();
    drain();
    chk("rst_mid_pass", 65'(pass_cnt), 65'(0));
    chk("rst_mid_state", 65'(state), 65'(2'b00));

    // Saturation of pass_cnt, then one mismatch.
    chk_en = 1'b0;
    repeat (65540) step(rnd_op(), 1'b0);
    chk_en = 1'b1;
    drain();
    chk("sat_pass", 65'(pass_cnt), 65'(16'hFFFF));
    o = rnd_op();
    o.bad = 1'b1;
    o.got = ref_sum(o) ^ 33'h1;
    step(o, 1'b0);
    drain();
    chk("sat_fail", 65'(fail_cnt), 65'(1));
    chk("sat_state", 65'(state), 65'(2'b10));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
